sum_arbiter: RTL



---
 rtl/sum_pkg.sv | 13 +
 rtl/my_SUM.sv | 34 +++
 rtl/sum_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sum_pkg.sv
// Shared definitions for the sum_arbiter slice: FSM state encoding and requester ids.
package sum_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t EXEC = 2'd1;
   localparam state_t RESP = 2'd2;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/my_SUM.sv
// Shared LENGTH-bit adder: sign-extended 8-bit result plus carry/overflow/negative/zero flags.
module my_SUM #(
   parameter int LENGTH = 5
) (
   input  logic [LENGTH-1:0] a,
   input  logic [LENGTH-1:0] b,
   output logic [7:0]        result,
   output logic              carry,
   output logic              overflow,
   output logic              negativo,
   output logic              zero
);

   logic [LENGTH:0]   sum_full;
   logic [LENGTH-1:0] low_sum;

   assign sum_full = {1'b0, a} + {1'b0, b};
   // Sum of the bits below the MSB; its top bit is the carry into bit LENGTH-1.
   assign low_sum  = {1'b0, a[LENGTH-2:0]} + {1'b0, b[LENGTH-2:0]};

   assign carry    = sum_full[LENGTH];
   assign overflow = sum_full[LENGTH] ^ low_sum[LENGTH-1];
   assign negativo = sum_full[LENGTH-1];
   assign zero     = (sum_full[LENGTH-1:0] == '0);

   generate
      if (LENGTH == 8) begin : g_full_width
         assign result = sum_full[7:0];
      end else begin : g_sign_extend
         assign result = {{(8-LENGTH){sum_full[LENGTH-1]}}, sum_full[LENGTH-1:0]};
      end
   endgenerate

endmodule

// File: rtl/sum_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single shared my_SUM adder.
//
//   state | meaning
//   IDLE  | waiting for a request; winner's operands and id latched on leaving
//   EXEC  | adder runs on latched operands; result/flags captured at end of cycle
//   RESP  | one-cycle done pulse to the served requester
module sum_arbiter #(
   parameter int LENGTH = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic [LENGTH-1:0] a0,
   input  logic [LENGTH-1:0] b0,
   input  logic              req1,
   input  logic [LENGTH-1:0] a1,
   input  logic [LENGTH-1:0] b1,
   output logic              done0,
   output logic              done1,
   output logic              owner,
   output logic              busy,
   output logic [7:0]        result,
   output logic              f_carry,
   output logic              f_overflow,
   output logic              f_negativo,
   output logic              f_zero
);
   import sum_pkg::*;

   generate
      if (LENGTH < 2 || LENGTH > 8) begin : g_bad_length
         $error("sum_arbiter: LENGTH must be in 2..8");
      end
   endgenerate

   state_t            state;
   state_t            state_nxt;
   logic              prio;
   logic              cur;
   logic              win;
   logic [LENGTH-1:0] op_a;
   logic [LENGTH-1:0] op_b;
   logic [7:0]        sum_res;
   logic              sum_carry;
   logic              sum_overflow;
   logic              sum_negativo;
   logic              sum_zero;

   // Lone requester wins outright; on a tie the round-robin pointer decides.
   function automatic logic pick_winner(input logic r0, input logic r1, input logic p);
      if (r0 && r1) return p;
      if (r1)       return REQ1;
      return REQ0;
   endfunction

   assign win = pick_winner(req0, req1, prio);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req0 || req1) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state == EXEC) || (state == RESP);
      done0 = (state == RESP) && (cur == REQ0);
      done1 = (state == RESP) && (cur == REQ1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur        <= REQ0;
         prio       <= REQ0;
         op_a       <= '0;
         op_b       <= '0;
         owner      <= REQ0;
         result     <= 8'h00;
         f_carry    <= 1'b0;
         f_overflow <= 1'b0;
         f_negativo <= 1'b0;
         f_zero     <= 1'b0;
      end else begin
         if (state == IDLE && (req0 || req1)) begin
            cur  <= win;
            op_a <= (win == REQ1) ? a1 : a0;
            op_b <= (win == REQ1) ? b1 : b0;
         end
         if (state == EXEC) begin
            result     <= sum_res;
            f_carry    <= sum_carry;
            f_overflow <= sum_overflow;
            f_negativo <= sum_negativo;
            f_zero     <= sum_zero;
            owner      <= cur;
            prio       <= ~cur;
         end
      end
   end

   my_SUM #(
      .LENGTH (LENGTH)
   ) u_sum (
      .a        (op_a),
      .b        (op_b),
      .result   (sum_res),
      .carry    (sum_carry),
      .overflow (sum_overflow),
      .negativo (sum_negativo),
      .zero     (sum_zero)
   );

endmodule
